acc_job_scheduler: RTL and testbench

Command queue and sequencer that sits in front of `dc_router_top`. It accepts accelerator jobs from the host in a small FIFO and drives the router's `instruction`/`offset`/`filesize` for one job at a time. Each job is held until the router reports `acc_done`. The scheduler then forces an idle gap with `instruction = 0` before issuing the next job, so the router returns to its idle state between jobs.

---
 rtl/acc_job_scheduler.sv | 171 +++++++++++++++++
 tb/tb_acc_job_scheduler.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_job_scheduler.sv
// Job queue and sequencer in front of dc_router_top: one job in flight, forced idle gap between jobs.
// Optional RUN watchdog enabled by defining ACC_SCHED_TIMEOUT_EN.
module acc_job_scheduler #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_instr,
    input  logic [31:0]              cmd_offset,
    input  logic [31:0]              cmd_filesize,
    output logic [31:0]              instruction,
    output logic [31:0]              offset,
    output logic [31:0]              filesize,
    input  logic                     acc_done,
    output logic                     busy,
    output logic                     job_done,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2} state_t;
    state_t state_reg, state_next;

    logic [65:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          cmd_ready_reg;
    logic          push, pop;

    logic [1:0]    instr_reg;
    logic [31:0]   offset_reg, filesize_reg;
    logic          armed_reg, armed_next;
    logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
    logic          job_done_reg, job_done_next;
    logic          load_job, clear_out;
    logic          done_q, timeout_hit;

    // NOP commands complete the handshake but never occupy a slot
    assign push   = cmd_valid && cmd_ready_reg && (cmd_instr != 2'b00);
    assign pop    = (state_reg == IDLE) && (count_reg != '0);
    assign done_q = acc_done && armed_reg;

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + CW'(1);
        else if (pop && !push)
            count_next = count_reg - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            cmd_ready_reg <= 1'b1;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg     <= count_next;
            cmd_ready_reg <= (count_next != CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= {cmd_instr, cmd_offset, cmd_filesize};
    end

    always_comb begin
        state_next    = state_reg;
        armed_next    = armed_reg;
        gap_cnt_next  = gap_cnt_reg;
        job_done_next = 1'b0;
        load_job      = 1'b0;
        clear_out     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0) begin
                    load_job   = 1'b1;
                    armed_next = 1'b0;
                    state_next = RUN;
                end
            end
            RUN: begin
                // a done still high from the previous job is ignored until it is seen low once
                if (!acc_done)
                    armed_next = 1'b1;
                if (done_q || timeout_hit) begin
                    job_done_next = done_q;
                    clear_out     = 1'b1;
                    gap_cnt_next  = GW'(GAP_CYCLES - 1);
                    state_next    = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_reg == '0)
                    state_next = IDLE;
                else
                    gap_cnt_next = gap_cnt_reg - GW'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            armed_reg    <= 1'b0;
            gap_cnt_reg  <= '0;
            job_done_reg <= 1'b0;
            instr_reg    <= '0;
            offset_reg   <= '0;
            filesize_reg <= '0;
        end else begin
            state_reg    <= state_next;
            armed_reg    <= armed_next;
            gap_cnt_reg  <= gap_cnt_next;
            job_done_reg <= job_done_next;
            if (load_job)
                {instr_reg, offset_reg, filesize_reg} <= mem[rd_ptr_reg];
            else if (clear_out)
                {instr_reg, offset_reg, filesize_reg} <= '0;
        end
    end

`ifdef ACC_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0] to_cnt_reg;
    logic          timeout_err_reg;

    assign timeout_hit = (state_reg == RUN) && (to_cnt_reg == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (load_job)
                to_cnt_reg <= '0;
            else if (state_reg == RUN)
                to_cnt_reg <= to_cnt_reg + TW'(1);
            // a genuine completion on the same cycle wins over the watchdog
            if (timeout_hit && !done_q)
                timeout_err_reg <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign cmd_ready   = cmd_ready_reg;
    assign queue_count = count_reg;
    assign instruction = {30'd0, instr_reg};
    assign offset      = offset_reg;
    assign filesize    = filesize_reg;
    assign job_done    = job_done_reg;
    assign busy        = (state_reg != IDLE) || (count_reg != '0);
endmodule

// File: tb/tb_acc_job_scheduler.sv
// Scoreboard bench for acc_job_scheduler: queued jobs are compared as they issue to the router.
module tb_acc_job_scheduler;
    localparam int DEPTH = 4;
    localparam int GAP   = 4;
    localparam int TMO   = 16;
`ifdef ACC_SCHED_TIMEOUT_EN
    localparam int HOLD  = 10;
`else
    localparam int HOLD  = 20;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_instr = 2'b00;
    logic [31:0] cmd_offset = '0;
    logic [31:0] cmd_filesize = '0;
    logic [31:0] instruction, offset, filesize;
    logic        acc_done = 1'b0;
    logic        busy, job_done, timeout_err;
    logic [2:0]  queue_count;

    acc_job_scheduler #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_instr(cmd_instr),
        .cmd_offset(cmd_offset), .cmd_filesize(cmd_filesize),
        .instruction(instruction), .offset(offset), .filesize(filesize),
        .acc_done(acc_done), .busy(busy), .job_done(job_done),
        .queue_count(queue_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  i;
        logic [31:0] o;
        logic [31:0] f;
    } job_t;

    job_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    // issue monitor: pops the scoreboard on each 0 -> nonzero instruction edge
    logic [31:0] prev_instr = '0;
    int zero_run = 100;
    always @(negedge clk) begin
        job_t exp;
        if (reset) begin
            prev_instr = '0;
            zero_run   = 100;
        end else begin
            if (instruction != 0 && prev_instr == 0) begin
                $display("issue instr=%0d offset=%0h filesize=%0d zeros_before=%0d",
                         instruction, offset, filesize, zero_run);
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL issue_unexpected: got instr=%0d offset=%0h, required no job",
                             instruction, offset);
                end else begin
                    exp = sb.pop_front();
                    if ({instruction, offset, filesize} !== {30'd0, exp.i, exp.o, exp.f}) begin
                        miscompares++;
                        $display("FAIL issue_data: got %0d/%0h/%0d, required %0d/%0h/%0d",
                                 instruction, offset, filesize, exp.i, exp.o, exp.f);
                    end
                end
                vectors++;
                if (zero_run < GAP + 1) begin
                    miscompares++;
                    $display("FAIL issue_gap: got %0d zero cycles, required >= %0d", zero_run, GAP + 1);
                end
            end
            zero_run   = (instruction == 0) ? zero_run + 1 : 0;
            prev_instr = instruction;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // leaves cmd_valid high after the handshake so callers can stream commands
    task automatic push_cmd(input logic [1:0] i, input logic [31:0] o, input logic [31:0] f);
        job_t j;
        cmd_valid    = 1'b1;
        cmd_instr    = i;
        cmd_offset   = o;
        cmd_filesize = f;
        for (int n = 0; n < 300; n++) begin
            if (cmd_ready) begin
                j.i = i; j.o = o; j.f = f;
                if (i != 2'b00) sb.push_back(j);
                tick();
                $display("push instr=%0d offset=%0h filesize=%0d", i, o, f);
                return;
            end
            tick();
        end
        vectors++;
        miscompares++;
        $display("FAIL push_timeout: got cmd_ready=0 for 300 cycles, required 1");
    endtask

    task automatic wait_issue(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (instruction != 0) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
        vectors++;
        miscompares++;
        $display("FAIL issue_timeout: got instruction=0 for 400 cycles, required a job");
    endtask

    task automatic finish_job(input int nwait);
        bit ok;
        wait_issue(ok);
        if (!ok) return;
        repeat (nwait) tick();
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        vectors++;
        if (job_done !== 1'b1) begin
            miscompares++;
            $display("FAIL finish_job_done: got job_done=%b, required 1", job_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        vectors++;
        if ({cmd_ready, queue_count, busy, job_done, timeout_err, instruction, offset, filesize}
            !== {1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 96'd0}) begin
            miscompares++;
            $display("FAIL reset_state: got ready=%b count=%0d busy=%b done=%b terr=%b instr=%0d, required 1/0/0/0/0/0",
                     cmd_ready, queue_count, busy, job_done, timeout_err, instruction);
        end
    endtask

    task automatic test_single_job();
        push_cmd(2'b01, 32'd100, 32'd40);
        cmd_valid = 1'b0;
        vectors++;
        if (queue_count !== 3'd1 || instruction !== 32'd0) begin
            miscompares++;
            $display("FAIL single_t1: got count=%0d instr=%0d, required 1/0", queue_count, instruction);
        end
        tick();
        vectors++;
        if ({instruction, offset, filesize} !== {32'd1, 32'd100, 32'd40} || queue_count !== 3'd0) begin
            miscompares++;
            $display("FAIL single_t2: got %0d/%0d/%0d count=%0d, required 1/100/40 count=0",
                     instruction, offset, filesize, queue_count);
        end
        repeat (HOLD - 1) tick();
        vectors++;
        if (instruction !== 32'd1 || job_done !== 1'b0) begin
            miscompares++;
            $display("FAIL single_hold: got instr=%0d done=%b, required 1/0", instruction, job_done);
        end
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        vectors++;
        if ({job_done, instruction, offset, filesize} !== {1'b1, 96'd0}) begin
            miscompares++;
            $display("FAIL single_done: got done=%b %0d/%0d/%0d, required 1 0/0/0",
                     job_done, instruction, offset, filesize);
        end
        for (int k = 2; k <= GAP; k++) begin
            tick();
            vectors++;
            if (instruction !== 32'd0 || job_done !== 1'b0) begin
                miscompares++;
                $display("FAIL single_gap%0d: got instr=%0d done=%b, required 0/0", k, instruction, job_done);
            end
        end
        repeat (2) tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_queue_full();
        fork
            begin
                push_cmd(2'b01, 32'h10, 32'd8);
                push_cmd(2'b10, 32'h20, 32'd9);
                push_cmd(2'b11, 32'h30, 32'd10);
                push_cmd(2'b01, 32'h40, 32'd11);
                push_cmd(2'b10, 32'h50, 32'd12);
                vectors++;
                if (queue_count !== 3'd4 || cmd_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL queue_full: got count=%0d ready=%b, required 4/0", queue_count, cmd_ready);
                end
                push_cmd(2'b11, 32'h60, 32'd13);
                cmd_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 6; j++) finish_job(3);
            end
        join
        repeat (8) tick();
    endtask

    task automatic test_stale_and_nop();
        bit ok;
        push_cmd(2'b01, 32'h100, 32'd4);
        push_cmd(2'b10, 32'h200, 32'd5);
        cmd_valid = 1'b0;
        wait_issue(ok);
        repeat (2) tick();
        acc_done = 1'b1;
        tick();
        vectors++;
        if (job_done !== 1'b1) begin
            miscompares++;
            $display("FAIL stale_first_done: got job_done=%b, required 1", job_done);
        end
        wait_issue(ok);
        for (int k = 0; k < 8; k++) begin
            tick();
            vectors++;
            if (job_done !== 1'b0 || instruction !== 32'd2) begin
                miscompares++;
                $display("FAIL stale_ignored: got done=%b instr=%0d, required 0/2", job_done, instruction);
            end
        end
        acc_done = 1'b0;
        tick();
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        vectors++;
        if (job_done !== 1'b1) begin
            miscompares++;
            $display("FAIL stale_rearmed_done: got job_done=%b, required 1", job_done);
        end
        repeat (8) tick();
        cmd_valid = 1'b1;
        cmd_instr = 2'b00;
        cmd_offset = 32'hdead;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL nop_ready: got cmd_ready=%b, required 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        $display("push instr=0 (nop) offset=dead");
        tick();
        vectors++;
        if (queue_count !== 3'd0) begin
            miscompares++;
            $display("FAIL nop_count: got queue_count=%0d, required 0", queue_count);
        end
        repeat (2) tick();
        vectors++;
        if (instruction !== 32'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL nop_idle: got instr=%0d busy=%b, required 0/0", instruction, busy);
        end
    endtask

    task automatic test_reset_mid_job();
        bit ok;
        push_cmd(2'b11, 32'h400, 32'd7);
        push_cmd(2'b01, 32'h410, 32'd8);
        push_cmd(2'b10, 32'h420, 32'd9);
        cmd_valid = 1'b0;
        wait_issue(ok);
        tick();
        vectors++;
        if (queue_count !== 3'd2 || instruction !== 32'd3) begin
            miscompares++;
            $display("FAIL midreset_pre: got count=%0d instr=%0d, required 2/3", queue_count, instruction);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        vectors++;
        if ({instruction, offset, filesize, queue_count, job_done, cmd_ready, busy, timeout_err}
            !== {96'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL midreset_state: got instr=%0d count=%0d done=%b ready=%b busy=%b, required 0/0/0/1/0",
                     instruction, queue_count, job_done, cmd_ready, busy);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++;
            if (instruction !== 32'd0 || job_done !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_quiet: got instr=%0d done=%b, required 0/0", instruction, job_done);
            end
        end
    endtask

`ifdef ACC_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        push_cmd(2'b01, 32'h300, 32'd1);
        push_cmd(2'b11, 32'h310, 32'd2);
        cmd_valid = 1'b0;
        wait_issue(ok);
        repeat (TMO - 1) tick();
        vectors++;
        if (timeout_err !== 1'b0 || instruction !== 32'd1) begin
            miscompares++;
            $display("FAIL timeout_early: got terr=%b instr=%0d, required 0/1", timeout_err, instruction);
        end
        tick();
        vectors++;
        if (timeout_err !== 1'b1 || job_done !== 1'b0 || instruction !== 32'd0) begin
            miscompares++;
            $display("FAIL timeout_fire: got terr=%b done=%b instr=%0d, required 1/0/0",
                     timeout_err, job_done, instruction);
        end
        finish_job(2);
        vectors++;
        if (timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_sticky: got terr=%b, required 1", timeout_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_job();
        test_queue_full();
        test_stale_and_nop();
        test_reset_mid_job();
`ifdef ACC_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        repeat (10) tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending jobs, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got simulation still running, required completion");
        $fatal(1, "global timeout");
    end
endmodule
